// File: rtl/vx_mem_perf_mon.sv
// Per-core memory-traffic performance monitor: counts load/store/response fires,
// tracks in-flight reads, accumulates Little's-law latency and peak occupancy.
module vx_mem_perf_mon #(
  parameter int NUM_REQS  = 4,
  parameter int CTR_BITS  = 44,
  parameter int PEND_BITS = 8,
  parameter int REQ_PIPE  = 1,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQS-1:0]  req_valid,
  input  logic [NUM_REQS-1:0]  req_ready,
  input  logic [NUM_REQS-1:0]  req_rw,
  input  logic [NUM_REQS-1:0]  rsp_valid,
  input  logic [NUM_REQS-1:0]  rsp_ready,
  input  logic                 freeze,
  input  logic                 clear,
  output logic [CTR_BITS-1:0]  loads,
  output logic [CTR_BITS-1:0]  stores,
  output logic [CTR_BITS-1:0]  responses,
  output logic [CTR_BITS-1:0]  latency,
  output logic [PEND_BITS-1:0] pending,
  output logic [PEND_BITS-1:0] max_pending,
  output logic                 err_underflow,
  output logic                 err_overflow
);

  localparam int CW = $clog2(NUM_REQS + 1);
  localparam int SW = PEND_BITS + 2;

  logic [NUM_REQS-1:0] req_fire;
  logic [NUM_REQS-1:0] rd_lanes;
  logic [NUM_REQS-1:0] wr_lanes;
  logic [CW-1:0]       rd_cnt;
  logic [CW-1:0]       wr_cnt;
  logic [CW-1:0]       rs_cnt;

  logic signed [SW-1:0] pend_sum;
  logic                 underflow;
  logic                 overflow;
  logic [PEND_BITS-1:0] pend_next;

  function automatic logic [CW-1:0] popcnt(input logic [NUM_REQS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [CTR_BITS-1:0] acc(input logic [CTR_BITS-1:0] a,
                                              input logic [CTR_BITS-1:0] b);
    logic [CTR_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CTR_BITS] && (SATURATE != 0)) return '1;
    return s[CTR_BITS-1:0];
  endfunction

  assign req_fire = req_valid & req_ready;

  // Request lanes optionally delayed one cycle to line up with the response path.
  generate
    if (REQ_PIPE != 0) begin : g_pipe
      logic [NUM_REQS-1:0] rd_q;
      logic [NUM_REQS-1:0] wr_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q <= '0;
          wr_q <= '0;
        end else begin
          rd_q <= req_fire & ~req_rw;
          wr_q <= req_fire & req_rw;
        end
      end
      assign rd_lanes = rd_q;
      assign wr_lanes = wr_q;
    end else begin : g_nopipe
      assign rd_lanes = req_fire & ~req_rw;
      assign wr_lanes = req_fire & req_rw;
    end
  endgenerate

  always_comb begin
    rd_cnt    = popcnt(rd_lanes);
    wr_cnt    = popcnt(wr_lanes);
    rs_cnt    = popcnt(rsp_valid & rsp_ready);
    pend_sum  = $signed({2'b00, pending}) + $signed(SW'(rd_cnt)) - $signed(SW'(rs_cnt));
    underflow = pend_sum < 0;
    overflow  = pend_sum > $signed({2'b00, {PEND_BITS{1'b1}}});
    if (underflow)     pend_next = '0;
    else if (overflow) pend_next = '1;
    else               pend_next = pend_sum[PEND_BITS-1:0];
  end

  // pending and error flags keep tracking under freeze so in-flight state stays exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      loads         <= '0;
      stores        <= '0;
      responses     <= '0;
      latency       <= '0;
      pending       <= '0;
      max_pending   <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      pending <= pend_next;
      if (clear) begin
        loads         <= '0;
        stores        <= '0;
        responses     <= '0;
        latency       <= '0;
        max_pending   <= pend_next;
        err_underflow <= 1'b0;
        err_overflow  <= 1'b0;
      end else begin
        err_underflow <= err_underflow | underflow;
        err_overflow  <= err_overflow | overflow;
        if (!freeze) begin
          loads     <= acc(loads, CTR_BITS'(rd_cnt));
          stores    <= acc(stores, CTR_BITS'(wr_cnt));
          responses <= acc(responses, CTR_BITS'(rs_cnt));
          latency   <= acc(latency, CTR_BITS'(pending));
          if (pend_next > max_pending) max_pending <= pend_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_mem_perf_mon.sv
// Bench for vx_mem_perf_mon: directed vector table, corner sequences and random
// traffic against an arithmetic reference model for three parameter sets.
module tb_vx_mem_perf_mon;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
  logic       freeze, clear;

  logic [43:0] m_loads, m_stores, m_rsps, m_lat;
  logic [7:0]  m_pend, m_maxp;
  logic        m_eu, m_eo;
  logic [3:0]  s_loads, s_stores, s_rsps, s_lat;
  logic [2:0]  s_pend, s_maxp;
  logic        s_eu, s_eo;
  logic [3:0]  w_loads, w_stores, w_rsps, w_lat;
  logic [2:0]  w_pend, w_maxp;
  logic        w_eu, w_eo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vx_mem_perf_mon #(.NUM_REQS(4), .CTR_BITS(44), .PEND_BITS(8), .REQ_PIPE(1), .SATURATE(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .freeze(freeze), .clear(clear),
    .loads(m_loads), .stores(m_stores), .responses(m_rsps), .latency(m_lat),
    .pending(m_pend), .max_pending(m_maxp), .err_underflow(m_eu), .err_overflow(m_eo));

  vx_mem_perf_mon #(.NUM_REQS(4), .CTR_BITS(4), .PEND_BITS(3), .REQ_PIPE(0), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .freeze(freeze), .clear(clear),
    .loads(s_loads), .stores(s_stores), .responses(s_rsps), .latency(s_lat),
    .pending(s_pend), .max_pending(s_maxp), .err_underflow(s_eu), .err_overflow(s_eo));

  vx_mem_perf_mon #(.NUM_REQS(4), .CTR_BITS(4), .PEND_BITS(3), .REQ_PIPE(0), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .freeze(freeze), .clear(clear),
    .loads(w_loads), .stores(w_stores), .responses(w_rsps), .latency(w_lat),
    .pending(w_pend), .max_pending(w_maxp), .err_underflow(w_eu), .err_overflow(w_eo));

  // Reference model: one entry per instance above.
  int          p_pipe[3] = '{1, 0, 0};
  int          p_cb[3]   = '{44, 4, 4};
  int          p_pb[3]   = '{8, 3, 3};
  bit          p_sat[3]  = '{1'b1, 1'b1, 1'b0};
  longint unsigned r_loads[3], r_stores[3], r_rsps[3], r_lat[3];
  int          r_pend[3], r_maxp[3], r_prd[3], r_pwr[3];
  bit          r_eu[3], r_eo[3];

  function automatic longint unsigned sadd(longint unsigned a, longint unsigned b, int bits, bit sat);
    longint unsigned lim = (64'd1 << bits) - 1;
    longint unsigned s   = a + b;
    if (s > lim) return sat ? lim : (s & lim);
    return s;
  endfunction

  task automatic model_step();
    int rd_now = $countones(req_valid & req_ready & ~req_rw);
    int wr_now = $countones(req_valid & req_ready & req_rw);
    int rs     = $countones(rsp_valid & rsp_ready);
    for (int k = 0; k < 3; k++) begin
      int rd, wr, pn, pmax;
      if (reset) begin
        r_loads[k] = 0; r_stores[k] = 0; r_rsps[k] = 0; r_lat[k] = 0;
        r_pend[k] = 0; r_maxp[k] = 0; r_prd[k] = 0; r_pwr[k] = 0;
        r_eu[k] = 0; r_eo[k] = 0;
        continue;
      end
      rd = p_pipe[k] != 0 ? r_prd[k] : rd_now;
      wr = p_pipe[k] != 0 ? r_pwr[k] : wr_now;
      r_prd[k] = rd_now;
      r_pwr[k] = wr_now;
      pmax = (1 << p_pb[k]) - 1;
      pn = r_pend[k] + rd - rs;
      if (clear) begin
        r_eu[k] = 0; r_eo[k] = 0;
      end else begin
        if (pn < 0)    r_eu[k] = 1;
        if (pn > pmax) r_eo[k] = 1;
      end
      if (pn < 0)    pn = 0;
      if (pn > pmax) pn = pmax;
      if (clear) begin
        r_loads[k] = 0; r_stores[k] = 0; r_rsps[k] = 0; r_lat[k] = 0;
        r_maxp[k] = pn;
      end else if (!freeze) begin
        r_loads[k]  = sadd(r_loads[k], rd, p_cb[k], p_sat[k]);
        r_stores[k] = sadd(r_stores[k], wr, p_cb[k], p_sat[k]);
        r_rsps[k]   = sadd(r_rsps[k], rs, p_cb[k], p_sat[k]);
        r_lat[k]    = sadd(r_lat[k], r_pend[k], p_cb[k], p_sat[k]);
        if (pn > r_maxp[k]) r_maxp[k] = pn;
      end
      r_pend[k] = pn;
    end
  endtask

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_one(int k, longint unsigned ld, longint unsigned st, longint unsigned rp,
                         longint unsigned lt, longint unsigned pd, longint unsigned mx,
                         longint unsigned eu, longint unsigned eo);
    check($sformatf("loads[%0d]", k), ld, r_loads[k]);
    check($sformatf("stores[%0d]", k), st, r_stores[k]);
    check($sformatf("responses[%0d]", k), rp, r_rsps[k]);
    check($sformatf("latency[%0d]", k), lt, r_lat[k]);
    check($sformatf("pending[%0d]", k), pd, longint'(r_pend[k]));
    check($sformatf("max_pending[%0d]", k), mx, longint'(r_maxp[k]));
    check($sformatf("err_underflow[%0d]", k), eu, longint'(r_eu[k]));
    check($sformatf("err_overflow[%0d]", k), eo, longint'(r_eo[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_one(0, m_loads, m_stores, m_rsps, m_lat, m_pend, m_maxp, m_eu, m_eo);
    cmp_one(1, s_loads, s_stores, s_rsps, s_lat, s_pend, s_maxp, s_eu, s_eo);
    cmp_one(2, w_loads, w_stores, w_rsps, w_lat, w_pend, w_maxp, w_eu, w_eo);
  endtask

  task automatic drive(logic rst, logic [3:0] rv, logic [3:0] rr, logic [3:0] rw,
                       logic [3:0] sv, logic [3:0] sr, logic frz, logic clr);
    reset = rst; req_valid = rv; req_ready = rr; req_rw = rw;
    rsp_valid = sv; rsp_ready = sr; freeze = frz; clear = clr;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rv, rr, rw, sv, sr;
    logic       clr;
    int         pend, loads, stores, rsps, lat, maxp, eu;
  } vec_t;

  vec_t tbl[19];
  longint unsigned lat_hold;

  initial begin
    // Expected values refer to the REQ_PIPE=1 default instance.
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1, 1, 0, 0, 0, 1, 0};
    tbl[3]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1, 1, 0, 0, 1, 1, 0};
    tbl[4]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1, 1, 0, 0, 2, 1, 0};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1, 1, 0, 0, 3, 1, 0};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 0, 1, 0, 1, 4, 1, 0};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 1, 0, 1, 4, 1, 0};
    tbl[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4, 4, 0, 0, 0, 4, 0};
    tbl[11] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4, 4, 0, 0, 4, 4, 0};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 0, 4, 0, 4, 8, 4, 0};
    tbl[13] = '{1'b0, 4'hF, 4'hF, 4'h5, 4'h0, 4'h0, 1'b0, 0, 4, 0, 4, 8, 4, 0};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2, 6, 2, 4, 8, 4, 0};
    tbl[15] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h3, 4'hF, 1'b0, 0, 6, 2, 6, 10, 4, 0};
    tbl[16] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 0, 6, 2, 7, 10, 4, 1};
    tbl[17] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 0, 6, 2, 7, 10, 4, 1};
    tbl[18] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].rr, tbl[i].rw, tbl[i].sv, tbl[i].sr, 1'b0, tbl[i].clr);
      tick();
      check($sformatf("tbl%0d_pending", i), m_pend, longint'(tbl[i].pend));
      check($sformatf("tbl%0d_loads", i), m_loads, longint'(tbl[i].loads));
      check($sformatf("tbl%0d_stores", i), m_stores, longint'(tbl[i].stores));
      check($sformatf("tbl%0d_responses", i), m_rsps, longint'(tbl[i].rsps));
      check($sformatf("tbl%0d_latency", i), m_lat, longint'(tbl[i].lat));
      check($sformatf("tbl%0d_max_pending", i), m_maxp, longint'(tbl[i].maxp));
      check($sformatf("tbl%0d_err_underflow", i), m_eu, longint'(tbl[i].eu));
    end

    // 20 single-lane loads into 4-bit counters: saturate vs wrap, 3-bit pending overflows.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    check("sat_loads", s_loads, 15);
    check("wrap_loads", w_loads, 4);
    check("main_loads20", m_loads, 20);
    check("sat_err_overflow", s_eo, 1);
    check("sat_pending_clamp", s_pend, 7);

    // Freeze with two reads in flight, then clear+freeze on a load-fire cycle.
    drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    check("frz_start_pending", m_pend, 2);
    lat_hold = r_lat[0];
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'h0, 4'h0, 4'h0, (i == 3) ? 4'h1 : 4'h0, 4'h1, 1'b1, 1'b0);
      tick();
    end
    check("frz_latency_held", m_lat, lat_hold);
    check("frz_pending_tracks", m_pend, 1);
    drive(1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    tick();
    check("clrfrz_loads", m_loads, 0);
    check("clrfrz_latency", m_lat, 0);
    check("clrfrz_sat_pending", s_pend, 2);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    check("clrfrz_main_pending", m_pend, 2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) == 0), 4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom & $urandom), 4'($urandom), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 49) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
